// File: rtl/ls_access_unit.sv
// ls_access_unit: odd-pipe load/store stage in front of the 32 KB local store.
// Takes one load or store per cycle. Forms a quadword-aligned local-store
// address and drives the single local-store port one cycle after acceptance.
// Load data returns to writeback LOAD_LAT cycles after acceptance.
//
// Bit numbering: the architecture numbers bits big-endian (bit 0 = MSB).
// Vectors here are declared [N-1:0], so architectural bit k of a 32-bit word
// is [31-k]. EA bits 17..31 are therefore ea[14:0], and bits 28..31 are ea[3:0].
//
// Optional build macro: LS_ALIGN_CHECK_EN adds the align_err / align_err_addr
// outputs, which report effective addresses that are not quadword aligned.
module ls_access_unit #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 128,
    parameter int LOAD_LAT = 6,     // legal range 2..16
    parameter int TAG_W    = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [31:0]       req_base,
    input  logic [31:0]       req_offset,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic [DATA_W-1:0] req_store_data,
    output logic              LS_write_en,
    output logic [ADDR_W-1:0] LS_addr,
    output logic [DATA_W-1:0] LS_data_in,
    input  logic [DATA_W-1:0] LS_data_out,
    output logic              wb_valid,
    output logic [TAG_W-1:0]  wb_tag,
    output logic [DATA_W-1:0] wb_data,
    output logic              busy
`ifdef LS_ALIGN_CHECK_EN
    ,
    output logic              align_err,
    output logic [31:0]       align_err_addr
`endif
);

    // Number of pure delay stages between the local-store capture and the
    // writeback register.
    localparam int NDLY = LOAD_LAT - 2;

    logic [31:0]       ea;
    logic [ADDR_W-1:0] ea_aligned;
    logic              accept;
    logic              take;

    logic              a_valid;
    logic              a_store;
    logic [TAG_W-1:0]  a_tag;

    logic              cap_valid;
    logic [TAG_W-1:0]  cap_tag;
    logic [DATA_W-1:0] cap_data;

    logic              fin_valid;
    logic [TAG_W-1:0]  fin_tag;
    logic [DATA_W-1:0] fin_data;
    logic              dly_busy;

    // The effective address wraps modulo 2^32; only the low ADDR_W bits reach
    // the local store and the low nibble is forced to zero.
    assign ea         = req_base + req_offset;
    assign ea_aligned = {ea[ADDR_W-1:4], 4'b0000};

    // Fully pipelined and in-order, so the unit is ready whenever it is out
    // of reset. A request arriving with flush is accepted but discarded.
    assign req_ready = ~rst;
    assign accept    = req_valid & req_ready;
    assign take      = accept & ~flush;

    // Stage A register; LS_addr and LS_data_in are this stage's address and
    // store data, so they simply hold their value on idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid    <= 1'b0;
            a_store    <= 1'b0;
            a_tag      <= '0;
            LS_addr    <= '0;
            LS_data_in <= '0;
        end else begin
            a_valid <= take;
            if (take) begin
                a_store <= req_is_store;
                a_tag   <= req_tag;
                LS_addr <= ea_aligned;
                if (req_is_store) begin
                    LS_data_in <= req_store_data;
                end
            end
        end
    end

    // A store in stage A writes regardless of flush, but never on a reset edge.
    assign LS_write_en = a_valid & a_store & ~rst;

    // Loads in stage A capture the asynchronous read data unless flushed.
    assign cap_valid = a_valid & ~a_store & ~flush;
    assign cap_tag   = a_tag;
    assign cap_data  = LS_data_out;

    generate
        if (NDLY == 0) begin : g_nodly
            assign fin_valid = cap_valid;
            assign fin_tag   = cap_tag;
            assign fin_data  = cap_data;
            assign dly_busy  = 1'b0;
        end else begin : g_dly
            logic [NDLY-1:0]   dly_valid;
            logic [TAG_W-1:0]  dly_tag  [NDLY];
            logic [DATA_W-1:0] dly_data [NDLY];

            // Fixed-length shift register for load results; flush clears every
            // valid bit in flight.
            always_ff @(posedge clk) begin
                if (rst) begin
                    dly_valid <= '0;
                    for (int i = 0; i < NDLY; i++) begin
                        dly_tag[i]  <= '0;
                        dly_data[i] <= '0;
                    end
                end else begin
                    dly_valid[0] <= cap_valid;
                    dly_tag[0]   <= cap_tag;
                    dly_data[0]  <= cap_data;
                    for (int i = 1; i < NDLY; i++) begin
                        dly_valid[i] <= dly_valid[i-1] & ~flush;
                        dly_tag[i]   <= dly_tag[i-1];
                        dly_data[i]  <= dly_data[i-1];
                    end
                end
            end

            assign fin_valid = dly_valid[NDLY-1] & ~flush;
            assign fin_tag   = dly_tag[NDLY-1];
            assign fin_data  = dly_data[NDLY-1];
            assign dly_busy  = |dly_valid;
        end
    endgenerate

    // Writeback register: one-cycle valid pulse, tag and data held until the
    // next load result arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_tag   <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= fin_valid;
            if (fin_valid) begin
                wb_tag  <= fin_tag;
                wb_data <= fin_data;
            end
        end
    end

    assign busy = a_valid | dly_busy | wb_valid;

`ifdef LS_ALIGN_CHECK_EN
    // Flag accepted requests whose EA is not quadword aligned and remember the
    // full unaligned EA of the most recent one.
    always_ff @(posedge clk) begin
        if (rst) begin
            align_err      <= 1'b0;
            align_err_addr <= '0;
        end else begin
            align_err <= accept & (ea[3:0] != 4'b0000);
            if (accept && (ea[3:0] != 4'b0000)) begin
                align_err_addr <= ea;
            end
        end
    end
`else
    // Misaligned EAs are silently truncated; the dropped EA bits go nowhere.
    logic ea_unused;
    assign ea_unused = ^{ea[31:ADDR_W], ea[3:0]};
`endif

endmodule

// File: tb/tb_ls_access_unit.sv
// Directed testbench for ls_access_unit with a behavioural 32 KB local store.
// Handles the optional LS_ALIGN_CHECK_EN build as well.
module tb_ls_access_unit;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         req_valid;
    logic         req_ready;
    logic         req_is_store;
    logic [31:0]  req_base;
    logic [31:0]  req_offset;
    logic [6:0]   req_tag;
    logic [127:0] req_store_data;
    logic         LS_write_en;
    logic [14:0]  LS_addr;
    logic [127:0] LS_data_in;
    logic [127:0] LS_data_out;
    logic         wb_valid;
    logic [6:0]   wb_tag;
    logic [127:0] wb_data;
    logic         busy;
`ifdef LS_ALIGN_CHECK_EN
    logic         align_err;
    logic [31:0]  align_err_addr;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic         init_mem = 1'b1;
    logic [127:0] mem [0:2047];

    always #5 clk = ~clk;

    ls_access_unit dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_is_store   (req_is_store),
        .req_base       (req_base),
        .req_offset     (req_offset),
        .req_tag        (req_tag),
        .req_store_data (req_store_data),
        .LS_write_en    (LS_write_en),
        .LS_addr        (LS_addr),
        .LS_data_in     (LS_data_in),
        .LS_data_out    (LS_data_out),
        .wb_valid       (wb_valid),
        .wb_tag         (wb_tag),
        .wb_data        (wb_data),
        .busy           (busy)
`ifdef LS_ALIGN_CHECK_EN
        ,
        .align_err      (align_err),
        .align_err_addr (align_err_addr)
`endif
    );

    // Known background contents of each quadword.
    function automatic logic [127:0] pat(input int i);
        return {32'(i), 32'hDEADBEEF, 32'(i * 3 + 1), 32'hCAFEF00D};
    endfunction

    // Local store model: asynchronous read, write on the clock edge.
    assign LS_data_out = mem[LS_addr[14:4]];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 2048; i++) mem[i] <= pat(i);
        end else if (LS_write_en === 1'b1) begin
            mem[LS_addr[14:4]] <= LS_data_in;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic v, input logic st,
                                 input logic [31:0] b, input logic [31:0] o,
                                 input logic [6:0] t, input logic [127:0] d);
        req_valid      = v;
        req_is_store   = st;
        req_base       = b;
        req_offset     = o;
        req_tag        = t;
        req_store_data = d;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] obs,
                               input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h, expected %h", name, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] d1, s4, r5;
        logic         seen_wb, seen_we;
        d1 = 128'h0123456789ABCDEF0123456789ABCDEF;
        s4 = 128'hFEDCBA9876543210FEDCBA9876543210;
        r5 = 128'h5555AAAA5555AAAA5555AAAA5555AAAA;

        rst   = 1'b1;
        flush = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        init_mem = 1'b0;
        tick();

        $display("[TB] reset state");
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_write_en", LS_write_en, 0);
        checkOutput("rst_addr", LS_addr, 0);
        checkOutput("rst_data_in", LS_data_in, 0);
        checkOutput("rst_wb_valid", wb_valid, 0);
        checkOutput("rst_wb_tag", wb_tag, 0);
        checkOutput("rst_wb_data", wb_data, 0);
        checkOutput("rst_busy", busy, 0);
        rst = 1'b0;
        #1;
        checkOutput("req_ready", req_ready, 1);

        $display("[TB] store then load same quadword");
        applyStimulus(1, 1, 32'h100, 32'h20, 0, d1);
        tick();
        checkOutput("t1_st_we", LS_write_en, 1);
        checkOutput("t1_st_addr", LS_addr, 15'h0120);
        checkOutput("t1_st_data", LS_data_in, d1);
        checkOutput("t1_busy", busy, 1);
`ifdef LS_ALIGN_CHECK_EN
        checkOutput("t1_align_err", align_err, 0);
`endif
        applyStimulus(1, 0, 32'h100, 32'h20, 7'd9, 0);
        tick();
        checkOutput("t1_ld_we", LS_write_en, 0);
        checkOutput("t1_ld_addr", LS_addr, 15'h0120);
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (4) tick();
        checkOutput("t1_wb_early", wb_valid, 0);
        tick();
        checkOutput("t1_wb_valid", wb_valid, 1);
        checkOutput("t1_wb_tag", wb_tag, 9);
        checkOutput("t1_wb_data", wb_data, d1);
        tick();
        checkOutput("t1_wb_pulse", wb_valid, 0);
        checkOutput("t1_wb_hold", wb_data, d1);
        checkOutput("t1_idle_busy", busy, 0);

        $display("[TB] address wrap and alignment");
        applyStimulus(1, 0, 32'h0000_7FF8, 32'h0000_001C, 7'd10, 0);
        tick();
        checkOutput("t2_addr", LS_addr, 15'h0010);
        checkOutput("t2_we", LS_write_en, 0);
`ifdef LS_ALIGN_CHECK_EN
        checkOutput("t2_align_err", align_err, 1);
        checkOutput("t2_align_addr", align_err_addr, 32'h0000_8014);
`endif
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("t2_addr_hold", LS_addr, 15'h0010);
`ifdef LS_ALIGN_CHECK_EN
        checkOutput("t2_align_pulse", align_err, 0);
        checkOutput("t2_align_addr_hold", align_err_addr, 32'h0000_8014);
`endif
        repeat (4) tick();
        checkOutput("t2_wb_valid", wb_valid, 1);
        checkOutput("t2_wb_tag", wb_tag, 10);
        checkOutput("t2_wb_data", wb_data, pat(1));

        $display("[TB] negative offset");
        applyStimulus(1, 0, 32'h40, 32'hFFFF_FFF0, 7'd12, 0);
        tick();
        checkOutput("t6_addr", LS_addr, 15'h0030);
`ifdef LS_ALIGN_CHECK_EN
        checkOutput("t6_align_err", align_err, 0);
`endif
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (5) tick();
        checkOutput("t6_wb_valid", wb_valid, 1);
        checkOutput("t6_wb_tag", wb_tag, 12);
        checkOutput("t6_wb_data", wb_data, pat(3));

        $display("[TB] back-to-back loads");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 0, 32'(k * 16), 0, 7'(k + 1), 0);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("t3_wb_valid_%0d", k), wb_valid, 1);
            checkOutput($sformatf("t3_wb_tag_%0d", k), wb_tag, 128'(k + 1));
            checkOutput($sformatf("t3_wb_data_%0d", k), wb_data, pat(k));
            tick();
        end
        checkOutput("t3_wb_end", wb_valid, 0);

        $display("[TB] flush");
        applyStimulus(1, 0, 32'h40, 0, 7'd5, 0);
        tick();
        applyStimulus(1, 0, 32'h50, 0, 7'd6, 0);
        tick();
        applyStimulus(1, 1, 32'h200, 0, 0, s4);
        tick();
        checkOutput("t4_st_we", LS_write_en, 1);
        checkOutput("t4_st_addr", LS_addr, 15'h0200);
        checkOutput("t4_busy_pre", busy, 1);
        flush = 1'b1;
        applyStimulus(1, 0, 32'h60, 0, 7'd7, 0);
        tick();
        flush = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t4_busy_post", busy, 0);
        checkOutput("t4_we_post", LS_write_en, 0);
        seen_wb = 1'b0;
        repeat (8) begin
            tick();
            if (wb_valid !== 1'b0) seen_wb = 1'b1;
        end
        checkOutput("t4_no_wb", seen_wb, 0);
        applyStimulus(1, 0, 32'h200, 0, 7'd8, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (5) tick();
        checkOutput("t4_rd_valid", wb_valid, 1);
        checkOutput("t4_rd_tag", wb_tag, 8);
        checkOutput("t4_rd_data", wb_data, s4);

        $display("[TB] reset mid-operation");
        applyStimulus(1, 0, 32'h70, 0, 7'd11, 0);
        tick();
        applyStimulus(1, 1, 32'h300, 0, 0, r5);
        tick();
        checkOutput("t5_st_we", LS_write_en, 1);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("t5_we_in_rst", LS_write_en, 0);
        tick();
        checkOutput("t5_req_ready", req_ready, 0);
        checkOutput("t5_addr", LS_addr, 0);
        checkOutput("t5_data_in", LS_data_in, 0);
        checkOutput("t5_wb_valid", wb_valid, 0);
        checkOutput("t5_wb_tag", wb_tag, 0);
        checkOutput("t5_wb_data", wb_data, 0);
        checkOutput("t5_busy", busy, 0);
        rst = 1'b0;
        seen_wb = 1'b0;
        seen_we = 1'b0;
        repeat (10) begin
            tick();
            if (wb_valid !== 1'b0) seen_wb = 1'b1;
            if (LS_write_en !== 1'b0) seen_we = 1'b1;
        end
        checkOutput("t5_no_wb", seen_wb, 0);
        checkOutput("t5_no_we", seen_we, 0);
        checkOutput("t5_mem_untouched", mem[48], pat(48));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ls_access_unit.md
Name: ls_access_unit

Overview:
- Odd-pipe load/store stage that sits directly upstream of the 32 KB local store.
- Accepts one load or store request per cycle and forms the effective address as a quadword-aligned 15-bit byte address.
- Drives the local store's single access port (write enable, address, write data) and captures its asynchronous read data.
- Returns load results to register-file writeback after a fixed latency.

Parameters:
- ADDR_W, 15, local-store byte-address width (32 KB)
- DATA_W, 128, quadword width
- LOAD_LAT, 6, cycles from request acceptance to wb_valid; legal range 2..16
- TAG_W, 7, destination-register tag width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  kill in-flight loads (branch mispredict)
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_is_store  in  1  1 = store quadword, 0 = load quadword
- req_base  in  [0:31]  base register preferred word
- req_offset  in  [0:31]  sign-extended immediate or index register
- req_tag  in  [0:TAG_W-1]  load destination tag
- req_store_data  in  [0:127]  store data
- LS_write_en  out  1  to local store
- LS_addr  out  [0:14]  to local store, always 16-byte aligned
- LS_data_in  out  [0:127]  store data to local store
- LS_data_out  in  [0:127]  asynchronous read data from local store
- wb_valid  out  1  load result valid (one-cycle pulse)
- wb_tag  out  [0:TAG_W-1]  load result tag
- wb_data  out  [0:127]  load result data
- busy  out  1  any request in flight

Behaviour:
- Clocking: one clock domain, clk. Reset is synchronous and active-high on rst; every register is cleared on the rst clock edge.
- Reset values: req_ready 0 while rst is high; LS_write_en 0; LS_addr 0; LS_data_in 0; wb_valid 0; wb_tag 0; wb_data 0; busy 0. All pipeline valid bits clear.
- Acceptance: a request is accepted on a clk edge where req_valid && req_ready. Outside reset, req_ready = 1 because the unit is fully pipelined and in-order.
- Effective address: EA = (req_base + req_offset) mod 2^32. LS_addr = EA bits [17:31] with bits [28:31] forced to 0, so the address wraps modulo 32 KB. An EA such as 0x00008010 maps to LS_addr 0x0010.
- Stage A (the acceptance edge, cycle T) registers: valid, is_store, aligned address, tag, data.
- Cycle T+1: LS_addr is driven from stage A.
  - Store: LS_write_en = 1 and LS_data_in = data for exactly this one cycle. Memory updates at the edge ending T+1.
  - Load: LS_write_en = 0, and LS_data_out is captured at the edge ending T+1.
- Idle cycles: LS_write_en = 0, and LS_addr / LS_data_in hold their last values.
- Load delay pipeline: the captured load data plus tag pass through a LOAD_LAT-2 stage shift register. wb_valid, wb_tag and wb_data are registered outputs, asserted in cycle T+LOAD_LAT for exactly one cycle. wb_data is held until the next load result.
- Ordering: loads return in order with fixed latency, so there is no writeback conflict. A load accepted the cycle after a store to the same quadword returns the new data, because the write lands before the load's address cycle.
- Stores produce no wb_valid.
- Flush:
  - On a cycle with flush = 1, every load currently in stage A or the delay pipeline is invalidated, and no wb_valid is produced for those loads.
  - A request accepted on a flush edge is also discarded.
  - A store already in stage A still completes its write; stores are never killed once accepted.
  - A wb_valid already being presented in the flush cycle is not retracted.
- busy = stage-A valid OR any delay-stage valid OR wb_valid.
- Reset mid-operation: all in-flight loads and stores are dropped. A store in stage A at the reset edge does not write (LS_write_en = 0 from that edge).

Optional Feature:
- Macro: LS_ALIGN_CHECK_EN.
- When defined:
  - Adds output align_err (1 bit, reset 0), a registered one-cycle pulse in cycle T+1 when the accepted request's EA bits [28:31] != 0.
  - The access still proceeds on the truncated aligned address.
  - Adds output align_err_addr [0:31], which holds the full unaligned EA of the most recent error.
- When undefined: the ports are absent and misaligned EAs are silently truncated.

Test Plan:
- Store then load, default LOAD_LAT=6:
  - Store base=0x100, offset=0x20, data=0x0123...CDEF at T0 -> LS_write_en=1, LS_addr=0x0120 in T0+1.
  - Load same address at T0+1 -> wb_valid at T0+7 with wb_data=0x0123...CDEF.
- Address wrap and alignment: base=0x00007FF8, offset=0x0000001C (EA=0x8014) -> LS_addr=0x0010. With LS_ALIGN_CHECK_EN: align_err pulse, align_err_addr=0x00008014.
- Back-to-back loads with tags 1,2,3,4 to addresses 0x0,0x10,0x20,0x30 -> four consecutive wb_valid cycles T+6..T+9 carrying tags 1..4 and the matching memory data.
- Flush at T+3 after loads with tags 5,6 at T, T+1, and a store at T+2 -> no wb_valid for tags 5 or 6; the store write still occurs in T+3; busy=0 by T+4.
- Assert rst while a store is in stage A and a load is in the delay pipeline -> no LS_write_en and no wb_valid afterwards; all outputs are 0 the cycle after the reset edge.
- Negative offset: base=0x40, offset=0xFFFFFFF0 -> LS_addr=0x0030.
